// File: rtl/us_delay_ctrl_pkg.sv
// rtl/us_delay_ctrl_pkg.sv - shared types and defaults for the microsecond delay sequencer
package us_delay_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/us_delay_ctrl_if.sv
// rtl/us_delay_ctrl_if.sv - request/response and tick-link signals of the delay sequencer
interface us_delay_ctrl_if #(
  parameter int WIDTH = us_delay_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] delay_us;
  logic             abort;
  logic             tick_in;
  logic             tick_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  // master: game-logic sequencer plus the tick generator feeding tick_in
  modport master (
    output start, delay_us, abort, tick_in,
    input  tick_en, busy, done, remaining
  );

  modport slave (
    input  start, delay_us, abort, tick_in,
    output tick_en, busy, done, remaining
  );

endinterface

// File: rtl/us_downcounter.sv
// rtl/us_downcounter.sv - loadable saturating down-counter with zero/one flags
module us_downcounter
  import us_delay_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             one
);

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == WIDTH'(1));

endmodule

// File: rtl/us_delay_ctrl.sv
// rtl/us_delay_ctrl.sv - counts 1 us ticks for a programmed delay with start/busy/done handshake
module us_delay_ctrl
  import us_delay_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic            clk_25MHz,
  input  logic            reset,
  us_delay_ctrl_if.slave  bus
);

  state_t           state;
  logic             busy_q;
  logic             tick_en_q;
  logic             done_q;
  logic             accept_start;
  logic             ctr_clr;
  logic             ctr_load;
  logic             ctr_dec;
  logic             final_tick;
  logic [WIDTH-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_one;

  // abort outranks start; a start while running only counts with RETRIGGER
  always_comb begin
    accept_start = 1'b0;
    ctr_clr      = 1'b0;
    ctr_load     = 1'b0;
    ctr_dec      = 1'b0;
    final_tick   = 1'b0;
    accept_start = bus.start && !bus.abort && ((state != ST_RUN) || RETRIGGER);
    ctr_clr      = bus.abort;
    ctr_load     = accept_start;
    ctr_dec      = (state == ST_RUN) && bus.tick_in && !bus.abort && !accept_start
                   && !cnt_zero;
    final_tick   = ctr_dec && cnt_one;
  end

  us_downcounter #(.WIDTH(WIDTH)) u_counter (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .clr       (ctr_clr),
    .load      (ctr_load),
    .load_val  (bus.delay_us),
    .dec       (ctr_dec),
    .count     (cnt),
    .zero      (cnt_zero),
    .one       (cnt_one)
  );

  always_ff @(posedge clk_25MHz) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      tick_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      tick_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus.abort) begin
        state <= ST_IDLE;
      end else if (accept_start) begin
        if (bus.delay_us != '0) begin
          state     <= ST_RUN;
          busy_q    <= 1'b1;
          tick_en_q <= 1'b1;
        end else begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        if (final_tick) begin
          state  <= ST_DONE;
          done_q <= 1'b1;
        end else begin
          state     <= ST_RUN;
          busy_q    <= 1'b1;
          tick_en_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.tick_en   = tick_en_q;
  assign bus.done      = done_q;
  assign bus.remaining = cnt;

endmodule
